// File: rtl/qamdemod_slicer_if.sv
// Streaming bus for the QAM slicer: I/Q sample input side and
// symbol-bit output side, each with its own valid/ready pair.
interface qamdemod_slicer_if #(
    parameter int SAMPLE_W = 12,
    parameter int BITS     = 4
) ();
    logic signed [SAMPLE_W-1:0] i;
    logic signed [SAMPLE_W-1:0] q;
    logic                       i_dv;
    logic                       i_rdy;
    logic [BITS-1:0]            s;
    logic                       o_sat;
    logic                       o_dv;
    logic                       o_rdy;

    // Environment side: supplies samples and accepts symbols.
    modport master (
        output i, q, i_dv, o_rdy,
        input  i_rdy, s, o_sat, o_dv
    );

    // Slicer side.
    modport slave (
        input  i, q, i_dv, o_rdy,
        output i_rdy, s, o_sat, o_dv
    );
endinterface

// File: rtl/qamdemod_slicer.sv
// Hard-decision QAM demapper. Each axis is offset so that the lowest
// decision region starts at zero, then the level index falls out of an
// arithmetic shift and a clamp. Two register stages with valid/ready.
module qamdemod_slicer #(
    parameter int MODULATION_ORDER = 16,
    parameter int SAMPLE_W         = 12,
    parameter int A_LOG2           = 8,
    parameter int GRAY             = 1
) (
    input logic clk,
    input logic rst,
    qamdemod_slicer_if.slave bus
);
    localparam int BITS   = $clog2(MODULATION_ORDER);
    localparam int AXB    = BITS / 2;
    localparam int L      = 1 << AXB;
    localparam int W_MIN  = AXB + A_LOG2 + 1;
    localparam int W_INT  = ((SAMPLE_W > W_MIN) ? SAMPLE_W : W_MIN) + 1;
    localparam int OFFSET_INT = L << A_LOG2;

    localparam logic signed [W_INT-1:0] OFFSET = W_INT'(OFFSET_INT);
    localparam logic signed [W_INT-1:0] K_MAX  = W_INT'(L - 1);
    localparam logic signed [W_INT-1:0] K_ZERO = '0;

    // Stage 1: offset samples
    logic                    v1_q,   v1_d;
    logic signed [W_INT-1:0] u_i_q,  u_i_d;
    logic signed [W_INT-1:0] u_q_q,  u_q_d;

    // Stage 2: output register
    logic                    o_dv_q, o_dv_d;
    logic [BITS-1:0]         s_q,    s_d;
    logic                    sat_q,  sat_d;

    logic                    adv2;
    logic                    in_rdy;
    logic                    accept;
    logic [AXB:0]            slice_i;
    logic [AXB:0]            slice_q;

    // Returns {saturated, field} for one offset axis value.
    function automatic logic [AXB:0] slice_axis(input logic signed [W_INT-1:0] u);
        logic signed [W_INT-1:0] k_raw;
        logic [AXB-1:0]          k;
        logic                    sat;
        k_raw = u >>> (A_LOG2 + 1);
        if (k_raw < K_ZERO) begin
            k   = '0;
            sat = 1'b1;
        end else if (k_raw > K_MAX) begin
            k   = AXB'(L - 1);
            sat = 1'b1;
        end else begin
            k   = k_raw[AXB-1:0];
            sat = 1'b0;
        end
        if (GRAY != 0) begin
            return {sat, k ^ (k >> 1)};
        end
        return {sat, k};
    endfunction

    // Flow control and next-state for both pipeline stages; i_rdy is held low during reset.
    always_comb begin
        adv2    = ~o_dv_q | bus.o_rdy;
        in_rdy  = ~rst & (~v1_q | adv2);
        accept  = bus.i_dv & in_rdy;
        slice_i = slice_axis(u_i_q);
        slice_q = slice_axis(u_q_q);

        v1_d   = v1_q;
        u_i_d  = u_i_q;
        u_q_d  = u_q_q;
        o_dv_d = o_dv_q;
        s_d    = s_q;
        sat_d  = sat_q;

        if (accept) begin
            v1_d  = 1'b1;
            u_i_d = W_INT'(bus.i) + OFFSET;
            u_q_d = W_INT'(bus.q) + OFFSET;
        end else if (adv2) begin
            v1_d = 1'b0;
        end

        if (adv2) begin
            o_dv_d = v1_q;
            if (v1_q) begin
                s_d   = {slice_i[AXB-1:0], slice_q[AXB-1:0]};
                sat_d = slice_i[AXB] | slice_q[AXB];
            end
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            u_i_q  <= '0;
            u_q_q  <= '0;
            o_dv_q <= 1'b0;
            s_q    <= '0;
            sat_q  <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            u_i_q  <= u_i_d;
            u_q_q  <= u_q_d;
            o_dv_q <= o_dv_d;
            s_q    <= s_d;
            sat_q  <= sat_d;
        end
    end

    assign bus.i_rdy = in_rdy;
    assign bus.s     = s_q;
    assign bus.o_sat = sat_q;
    assign bus.o_dv  = o_dv_q;

endmodule

// File: tb/tb_qamdemod_slicer.sv
// Testbench for qamdemod_slicer: eight configurations (every M with both
// field codings), directed vectors, multi-cycle corner sequences and a
// random sweep against a nearest-level reference slicer.
module tb_qamdemod_slicer;
    localparam int NCFG = 8;
    localparam int SW   = 12;
    localparam int NSYM = 1250;

    logic clk = 1'b0;
    logic rst;

    logic signed [SW-1:0] sw_i    [NCFG];
    logic signed [SW-1:0] sw_q    [NCFG];
    logic                 sw_dv   [NCFG];
    logic                 sw_ordy [NCFG];
    logic                 sw_irdy [NCFG];
    logic                 sw_odv  [NCFG];
    logic                 sw_sat  [NCFG];
    logic [7:0]           sw_s    [NCFG];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic int cfg_m(input int g);
        return 4 << (2 * (g / 2));
    endfunction

    function automatic int cfg_alog2(input int g);
        case (g)
            0: return 8;
            1: return 9;
            2: return 7;
            3: return 8;
            4: return 6;
            5: return 7;
            6: return 5;
            default: return 6;
        endcase
    endfunction

    function automatic int cfg_gray(input int g);
        return g % 2;
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : sw
        localparam int BW = $clog2(cfg_m(g));
        qamdemod_slicer_if #(.SAMPLE_W(SW), .BITS(BW)) bus ();
        assign bus.i     = sw_i[g];
        assign bus.q     = sw_q[g];
        assign bus.i_dv  = sw_dv[g];
        assign bus.o_rdy = sw_ordy[g];
        assign sw_irdy[g] = bus.i_rdy;
        assign sw_odv[g]  = bus.o_dv;
        assign sw_sat[g]  = bus.o_sat;
        assign sw_s[g]    = 8'(bus.s);
        qamdemod_slicer #(
            .MODULATION_ORDER(cfg_m(g)),
            .SAMPLE_W(SW),
            .A_LOG2(cfg_alog2(g)),
            .GRAY(cfg_gray(g))
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus.slave)
        );
    end

    // Nearest constellation level by distance; ties go to the higher index.
    // Result is (sat << 8) | field.
    function automatic int ref_axis(input int x, input int g);
        int l, a, best_k, best_d, d, lvl, field;
        bit sat;
        l = 1 << ($clog2(cfg_m(g)) / 2);
        a = 1 << cfg_alog2(g);
        best_k = 0;
        best_d = 32'h7fffffff;
        for (int k = 0; k < l; k++) begin
            lvl = (2 * k - (l - 1)) * a;
            d = x - lvl;
            if (d < 0) d = -d;
            if (d <= best_d) begin
                best_d = d;
                best_k = k;
            end
        end
        sat = (x < -l * a) || (x >= l * a);
        field = (cfg_gray(g) != 0) ? (best_k ^ (best_k >> 1)) : best_k;
        return (int'(sat) << 8) | field;
    endfunction

    function automatic int ref_symbol(input int xi, input int xq, input int g);
        int ai, aq, axb;
        axb = $clog2(cfg_m(g)) / 2;
        ai = ref_axis(xi, g);
        aq = ref_axis(xq, g);
        return ((ai | aq) & 32'h100) | ((ai & 8'hff) << axb) | (aq & 8'hff);
    endfunction

    function automatic int rand_sample(input int g);
        int l, a, x;
        l = 1 << ($clog2(cfg_m(g)) / 2);
        a = 1 << cfg_alog2(g);
        if ($urandom_range(0, 3) == 0) begin
            x = (2 * int'($urandom_range(0, l)) - (l - 2)) * a + int'($urandom_range(0, 2)) - 1;
        end else begin
            x = int'($urandom_range(0, 4095)) - 2048;
        end
        if (x > 2047) x = 2047;
        if (x < -2048) x = -2048;
        return x;
    endfunction

    task automatic checkOutput(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input int g, input int iv, input int qv, input bit dv);
        sw_i[g]  = SW'(iv);
        sw_q[g]  = SW'(qv);
        sw_dv[g] = dv;
    endtask

    task automatic idleAll();
        for (int g = 0; g < NCFG; g++) begin
            applyStimulus(g, 0, 0, 1'b0);
            sw_ordy[g] = 1'b1;
        end
    endtask

    typedef struct {
        int g;
        int iv;
        int qv;
        int exp_s;
        int exp_sat;
    } vec_t;

    vec_t vecs[10];
    int   bb_i[3];
    int   bb_q[3];
    int   bb_s[3];
    int   bp_i[6];
    int   bp_q[6];
    int   exp_q[NCFG][$];
    int   sent[NCFG];
    int   got[NCFG];

    initial begin
        int t, in_n, out_n, prev_s, max_occ, e, cyc;
        bit stalled_prev, saw_block, stale, done;

        vecs[0] = '{3,     0,  -512, 'hd,  0};
        vecs[1] = '{3,  2047, -2048, 'h8,  1};
        vecs[2] = '{4,   448,  -448, 'h38, 0};
        vecs[3] = '{4,    64,   -64, 'h23, 0};
        vecs[4] = '{3, -1024,  1023, 'h2,  0};
        vecs[5] = '{3,  1024, -1025, 'h8,  1};
        vecs[6] = '{4,  -512,   511, 'h7,  0};
        vecs[7] = '{4,  -513,     0, 'h4,  1};
        vecs[8] = '{3,  -512,   511, 'h7,  0};
        vecs[9] = '{3, -2048,  2047, 'h2,  1};
        bb_i = '{768, -256, -768};
        bb_q = '{-768, 256, 768};
        bb_s = '{'h8, 'h7, 'h2};
        bp_i = '{768, -256, -768, 0, 2047, -600};
        bp_q = '{-768, 256, 768, -512, 100, -2048};

        // Reset state
        rst = 1'b1;
        idleAll();
        #3;
        for (int g = 0; g < NCFG; g++) begin
            checkOutput($sformatf("reset_dv cfg%0d", g), int'(sw_odv[g]), 0);
            checkOutput($sformatf("reset_s cfg%0d", g), int'(sw_s[g]), 0);
            checkOutput($sformatf("reset_irdy cfg%0d", g), int'(sw_irdy[g]), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors, one symbol at a time
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            applyStimulus(vecs[n].g, vecs[n].iv, vecs[n].qv, 1'b1);
            #1;
            t = 0;
            while (!sw_irdy[vecs[n].g] && t < 10) begin
                @(negedge clk);
                #1;
                t++;
            end
            checkOutput($sformatf("vec%0d_accept", n), int'(t < 10), 1);
            @(negedge clk);
            sw_dv[vecs[n].g] = 1'b0;
            #1;
            t = 0;
            while (!sw_odv[vecs[n].g] && t < 10) begin
                @(negedge clk);
                #1;
                t++;
            end
            checkOutput($sformatf("vec%0d_dv", n), int'(sw_odv[vecs[n].g]), 1);
            checkOutput($sformatf("vec%0d_s", n), int'(sw_s[vecs[n].g]), vecs[n].exp_s);
            checkOutput($sformatf("vec%0d_sat", n), int'(sw_sat[vecs[n].g]), vecs[n].exp_sat);
        end
        @(negedge clk);
        @(negedge clk);

        // Back-to-back stream: outputs on cycles 2,3,4 after first accept
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c < 3) applyStimulus(3, bb_i[c], bb_q[c], 1'b1);
            else sw_dv[3] = 1'b0;
            #1;
            if (c < 3) checkOutput($sformatf("b2b_irdy%0d", c), int'(sw_irdy[3]), 1);
            if (c >= 2) begin
                checkOutput($sformatf("b2b_dv%0d", c), int'(sw_odv[3]), 1);
                checkOutput($sformatf("b2b_s%0d", c), int'(sw_s[3]), bb_s[c-2]);
                checkOutput($sformatf("b2b_sat%0d", c), int'(sw_sat[3]), 0);
            end else begin
                checkOutput($sformatf("b2b_dv_early%0d", c), int'(sw_odv[3]), 0);
            end
        end
        @(negedge clk);

        // Backpressure: o_rdy low for 4 cycles mid-stream
        in_n = 0;
        out_n = 0;
        prev_s = 0;
        max_occ = 0;
        stalled_prev = 1'b0;
        saw_block = 1'b0;
        for (int c = 0; c < 40 && out_n < 6; c++) begin
            @(negedge clk);
            sw_ordy[3] = !(c >= 3 && c < 7);
            if (in_n < 6) applyStimulus(3, bp_i[in_n], bp_q[in_n], 1'b1);
            else sw_dv[3] = 1'b0;
            #1;
            if (stalled_prev) begin
                checkOutput($sformatf("bp_stall_s c%0d", c), int'(sw_s[3]), prev_s);
                checkOutput($sformatf("bp_stall_dv c%0d", c), int'(sw_odv[3]), 1);
            end
            stalled_prev = sw_odv[3] && !sw_ordy[3];
            prev_s = int'(sw_s[3]);
            if (!sw_irdy[3]) saw_block = 1'b1;
            if (sw_odv[3] && sw_ordy[3]) begin
                if (out_n < 6)
                    checkOutput($sformatf("bp_sym%0d", out_n), (int'(sw_sat[3]) << 8) | int'(sw_s[3]),
                                ref_symbol(bp_i[out_n], bp_q[out_n], 3));
                out_n++;
            end
            if (sw_dv[3] && sw_irdy[3]) in_n++;
            if (in_n - out_n > max_occ) max_occ = in_n - out_n;
        end
        sw_dv[3] = 1'b0;
        sw_ordy[3] = 1'b1;
        checkOutput("bp_count", out_n, 6);
        checkOutput("bp_irdy_dropped", int'(saw_block), 1);
        checkOutput("bp_max_buffered", max_occ, 2);
        @(negedge clk);
        @(negedge clk);

        // Reset with two symbols buffered
        sw_ordy[3] = 1'b0;
        @(negedge clk);
        applyStimulus(3, 768, -768, 1'b1);
        @(negedge clk);
        applyStimulus(3, -256, 256, 1'b1);
        @(negedge clk);
        sw_dv[3] = 1'b0;
        #1;
        checkOutput("rst_pre_dv", int'(sw_odv[3]), 1);
        checkOutput("rst_pre_s", int'(sw_s[3]), 'h8);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_dv", int'(sw_odv[3]), 0);
        checkOutput("rst_async_s", int'(sw_s[3]), 0);
        checkOutput("rst_async_sat", int'(sw_sat[3]), 0);
        checkOutput("rst_async_irdy", int'(sw_irdy[3]), 0);
        @(negedge clk);
        rst = 1'b0;
        sw_ordy[3] = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (sw_odv[3]) stale = 1'b1;
        end
        checkOutput("rst_no_stale", int'(stale), 0);
        @(negedge clk);
        applyStimulus(3, -768, 768, 1'b1);
        #1;
        checkOutput("rst_next_accept", int'(sw_irdy[3]), 1);
        @(negedge clk);
        sw_dv[3] = 1'b0;
        #1;
        checkOutput("rst_next_dv1", int'(sw_odv[3]), 0);
        @(negedge clk);
        #1;
        checkOutput("rst_next_dv2", int'(sw_odv[3]), 1);
        checkOutput("rst_next_s", int'(sw_s[3]), 'h2);
        @(negedge clk);

        // Random sweep over every configuration
        for (int g = 0; g < NCFG; g++) begin
            sent[g] = 0;
            got[g] = 0;
        end
        done = 1'b0;
        cyc = 0;
        while (!done && cyc < 30000) begin
            @(negedge clk);
            for (int g = 0; g < NCFG; g++) begin
                if (sent[g] < NSYM && $urandom_range(0, 3) != 0)
                    applyStimulus(g, rand_sample(g), rand_sample(g), 1'b1);
                else
                    applyStimulus(g, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048, 1'b0);
                sw_ordy[g] = ($urandom_range(0, 3) != 0);
            end
            #1;
            done = 1'b1;
            for (int g = 0; g < NCFG; g++) begin
                if (sw_odv[g] && sw_ordy[g]) begin
                    if (exp_q[g].size() == 0) begin
                        checkOutput($sformatf("sweep_spurious cfg%0d", g), 1, 0);
                    end else begin
                        e = exp_q[g].pop_front();
                        checkOutput($sformatf("sweep cfg%0d sym%0d", g, got[g]),
                                    (int'(sw_sat[g]) << 8) | int'(sw_s[g]), e);
                    end
                    got[g]++;
                end
                if (sw_dv[g] && sw_irdy[g]) begin
                    exp_q[g].push_back(ref_symbol(int'(sw_i[g]), int'(sw_q[g]), g));
                    sent[g]++;
                end
                if (got[g] < NSYM) done = 1'b0;
            end
            cyc++;
        end
        idleAll();
        for (int g = 0; g < NCFG; g++) begin
            checkOutput($sformatf("sweep_count cfg%0d", g), got[g], NSYM);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/qamdemod_slicer.md
Name: qamdemod_slicer

Overview:
- Hard-decision QAM demapper; the receive-side inverse of the QAM modulator.
- Takes signed I/Q baseband samples and slices each axis to the nearest constellation level.
- Per-axis level indices are packed into symbol bits: I half in the upper bits, Q half in the lower bits.
- Two-stage pipeline with valid/ready flow control and a per-symbol saturation flag; sits between the equaliser and the bit deinterleaver.

Parameters:
- MODULATION_ORDER, 16, constellation size M; legal values 4, 16, 64, 256. L = sqrt(M) levels per axis; BITS = $clog2(M); AXB = BITS/2.
- SAMPLE_W, 12, signed I/Q sample width.
- A_LOG2, 8, half level spacing is A = 2^A_LOG2; axis level k has amplitude (2k-(L-1))*A.
- GRAY, 1, 1: each axis field is Gray(k); 0: field is binary k.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i  in  SAMPLE_W  signed in-phase sample
- q  in  SAMPLE_W  signed quadrature sample
- i_dv  in  1  input valid
- i_rdy  out  1  input ready; transfer occurs when i_dv & i_rdy
- s  out  BITS  symbol bits, {I field, Q field}
- o_sat  out  1  I or Q sample was outside the slicing range and was clamped
- o_dv  out  1  output valid
- o_rdy  in  1  downstream ready; transfer occurs when o_dv & o_rdy

Behaviour:
- Reset: asynchronous assert and synchronous release by the usual system reset. While rst is high: o_dv=0, s=0, o_sat=0, stage-1 valid=0, i_rdy=0. In-flight symbols are discarded; nothing is output for them after release.
- Internal width: W_INT = max(SAMPLE_W, $clog2(L)+A_LOG2+1)+1, signed. No intermediate overflow is allowed for any input value.
- Stage 1 (register on accept): compute u = x + L*A for each axis, sign-extended to W_INT.
- Stage 2 (register to output):
  - k_raw = u >>> (A_LOG2+1) (arithmetic shift, i.e. floor).
  - k = 0 if k_raw < 0; L-1 if k_raw > L-1; otherwise k_raw.
  - Decision boundaries lie at 2jA-(L-2)A; a sample exactly on a boundary takes the higher index.
  - Axis sat = (k_raw < 0) | (k_raw > L-1); o_sat = sat_I | sat_Q.
  - Field = GRAY ? (k ^ (k>>1)) : k.
- Latency: 2 cycles from accept to o_dv with no backpressure. Sustained throughput is 1 symbol/clk.
- Flow control:
  - adv2 = ~o_dv | o_rdy.
  - i_rdy = ~v1 | adv2 (combinational from o_rdy, by design).
  - Stage 1 loads on i_dv & i_rdy. v1 clears when stage 2 takes its contents and no new input arrives.
  - Output register loads from stage 1 when adv2 & v1. o_dv clears on o_rdy when v1=0.
- Stall: s/o_sat/o_dv hold stable while o_dv & ~o_rdy. Stage-1 contents hold. At most 2 symbols are buffered.
- Simultaneous accept and output transfer in one cycle: both happen, and no bubble is inserted.
- i/q values with i_dv=0 are ignored.

Test Plan:
- M=16, SAMPLE_W=12, A_LOG2=8, GRAY=1; reset then send I/Q pairs (768,-768), (-256,256), (-768,768) back to back with o_rdy=1 -> s=4'b1000, 4'b0111, 4'b0010 on cycles 2,3,4 after the first accept; o_sat=0; o_dv continuous for 3 cycles.
- Boundary/saturation, M=16: I=0,Q=-512 -> k_I=2, k_Q=1, s=4'b1101, o_sat=0. I=2047,Q=-2048 -> k=3,0, s=4'b1000, o_sat=1.
- GRAY=0, M=64 (L=8), A_LOG2=6: I=7*64=448, Q=-448 -> s=6'b111000. I=64, Q=-64 -> s=6'b100011.
- Backpressure: stream 6 symbols with o_rdy held low for 4 cycles mid-stream -> i_rdy drops after 2 buffered symbols; s/o_dv stable during the stall; all 6 symbols delivered in order with none lost or duplicated.
- Reset mid-operation: assert rst with 2 symbols buffered -> o_dv=0 and s=0 immediately (asynchronously); after release no stale symbol appears, and the next input emerges with 2-cycle latency.
- Random sweep for all M and GRAY settings against a reference slicer model -> bit-exact s and o_sat for 10k symbols with random i_dv/o_rdy.
